riscv_fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core, directly upstream of imem. It holds the program counter and drives imem's word-aligned address, a combinational read. It captures the returned instruction into the IF/ID pipeline register with stall, flush and branch-redirect control. It also detects EBREAK to halt fetch and counts retired fetches for bring-up benches.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/if_id_reg.sv | 20 ++
 rtl/riscv_fetch_stage.sv | 84 ++++++++
 tb/tb_riscv_fetch_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the RV32I fetch stage.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSTR     = 32'h0010_0073;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        RUN,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        instr:    NOP_INSTR,
        pc:       32'h0,
        pc_plus4: 32'h0,
        valid:    1'b0
    };

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; clear beats enable, reset beats both.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   clr,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk) begin
        if (reset || clr)
            q <= IF_ID_BUBBLE;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: PC, imem addressing, IF/ID capture, EBREAK halt and fetch counting.
module riscv_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_a,
    input  logic [31:0]     imem_rd,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic [XLEN-1:0] pc_f,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d,
    output logic            halted,
    output logic            misalign_err,
    output logic [31:0]     fetch_count
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc_next, pc_plus4_f;
    logic            squash, load_valid;
    if_id_t          if_id_next, if_id_q;

    assign pc_plus4_f = pc_f + XLEN'(4);
    assign imem_a     = pc_f;
    assign halted     = (state == HALT);

    always_ff @(posedge clk) begin
        if (reset)
            state <= RUN;
        else
            state <= state_next;
    end

    // A redirect squashes whatever sits in D, including a speculative EBREAK.
    always_comb begin
        squash     = flush_d | pc_src_e;
        load_valid = !squash && !stall_d && state == RUN;
        state_next = state;
        if (pc_src_e)
            state_next = RUN;
        else if (load_valid && imem_rd == EBREAK_INSTR)
            state_next = HALT;
        pc_next = pc_src_e ? {pc_target_e[XLEN-1:2], 2'b00}
                : (stall_f || state == HALT) ? pc_f : pc_plus4_f;
        if_id_next = (state == HALT) ? IF_ID_BUBBLE
                   : '{instr: imem_rd, pc: pc_f, pc_plus4: pc_plus4_f, valid: 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f         <= RESET_PC;
            misalign_err <= 1'b0;
            fetch_count  <= 32'h0;
        end else begin
            pc_f         <= pc_next;
            misalign_err <= misalign_err | (pc_src_e && pc_target_e[1:0] != 2'b00);
            fetch_count  <= fetch_count + 32'(load_valid);
        end
    end

    if_id_reg u_if_id (
        .clk   (clk),
        .reset (reset),
        .en    (!stall_d),
        .clr   (squash),
        .d     (if_id_next),
        .q     (if_id_q)
    );

    assign instr_d    = if_id_q.instr;
    assign pc_d       = if_id_q.pc;
    assign pc_plus4_d = if_id_q.pc_plus4;
    assign valid_d    = if_id_q.valid;

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// tb_riscv_fetch_stage: directed plus random stimulus, scoreboard against a cycle-level model.
module tb_riscv_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] EBK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        reset = 1'b1, stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pc_src_e = 1'b0;
    logic [31:0] pc_target_e = 32'h0, imem_rd = 32'h0;
    logic [31:0] imem_a, pc_f, instr_d, pc_d, pc_plus4_d, fetch_count;
    logic        valid_d, halted, misalign_err;

    always #5 clk = ~clk;

    riscv_fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .imem_a       (imem_a),
        .imem_rd      (imem_rd),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .pc_src_e     (pc_src_e),
        .pc_target_e  (pc_target_e),
        .pc_f         (pc_f),
        .instr_d      (instr_d),
        .pc_d         (pc_d),
        .pc_plus4_d   (pc_plus4_d),
        .valid_d      (valid_d),
        .halted       (halted),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    // Sparse memory: word n at address 4n unless overridden.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : {2'b00, a[31:2]};
    endfunction

    typedef struct {
        logic [31:0] pc, instr, pcd, pc4, cnt;
        logic        valid, halt, mis, pck;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0, n_bad = 0;

    logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_cnt;
    logic        m_valid, m_halt, m_mis, m_pck;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
        end
    endtask

    task automatic cyc(input logic rst, input logic sf, input logic sd, input logic fl,
                       input logic src, input logic [31:0] tgt);
        logic [31:0] w;
        logic        load, nh;
        @(negedge clk);
        #1;
        reset = rst; stall_f = sf; stall_d = sd; flush_d = fl; pc_src_e = src; pc_target_e = tgt;
        imem_rd = rd(imem_a);
        w = rd(m_pc);
        if (rst) begin
            m_pc = 32'h0; m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
            m_valid = 1'b0; m_halt = 1'b0; m_mis = 1'b0; m_pck = 1'b1;
        end else begin
            load = !(fl || src) && !sd && !m_halt;
            nh = src ? 1'b0 : (load && w == EBK) ? 1'b1 : m_halt;
            if (fl || src) begin
                m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_pck = 1'b1;
            end else if (!sd && m_halt) begin
                m_instr = NOP; m_valid = 1'b0; m_pck = 1'b0;
            end else if (!sd) begin
                m_instr = w; m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pck = 1'b1;
            end
            m_mis = m_mis | (src && tgt[1:0] != 2'b00);
            m_cnt = m_cnt + (load ? 32'd1 : 32'd0);
            m_pc = src ? (tgt & 32'hFFFF_FFFC) : (sf || m_halt) ? m_pc : m_pc + 32'd4;
            m_halt = nh;
        end
        q.push_back('{pc: m_pc, instr: m_instr, pcd: m_pcd, pc4: m_pc4, cnt: m_cnt,
                      valid: m_valid, halt: m_halt, mis: m_mis, pck: m_pck});
    endtask

    task automatic run(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic jump(input logic [31:0] tgt);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tgt);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc_f", pc_f, e.pc);
            chk("imem_a", imem_a, e.pc);
            chk("instr_d", instr_d, e.instr);
            if (e.pck) begin
                chk("pc_d", pc_d, e.pcd);
                chk("pc_plus4_d", pc_plus4_d, e.pc4);
            end
            chk("valid_d", 32'(valid_d), 32'(e.valid));
            chk("halted", 32'(halted), 32'(e.halt));
            chk("misalign_err", 32'(misalign_err), 32'(e.mis));
            chk("fetch_count", fetch_count, e.cnt);
        end
    end

    initial begin
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        run(6);
        jump(32'h8);
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        run(2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
        run(2);
        jump(32'h42);
        run(2);
        mem[32'h10] = EBK;
        jump(32'h0);
        run(8);
        jump(32'h0);
        run(3);
        jump(32'h10);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        run(3);
        jump(32'h10);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        run(3);
        jump(32'h10);
        run(3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        run(2);
        mem.delete();
        jump(32'hFFFF_FFFC);
        run(2);
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] t;
            if ($urandom_range(0, 40) == 0) mem[{24'h0, 6'($urandom_range(0, 63)), 2'b00}] = EBK;
            if ($urandom_range(0, 60) == 0) mem.delete();
            t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                            : 32'($urandom_range(0, 255));
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, t);
        end
        repeat (3) @(negedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations pending, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
